// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//
// This block holds the APU pulse channel's timer, its duty sequencer and its
// length counter. It owns the 11-bit period register. That register is
// wired out to the sweep unit, and the sweep unit can update it through
// sweep_update/sweep_period. The block decodes the CPU writes to
// $4000/$4002/$4003 and produces the 4-bit sample for the mixer.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   cpu_clk_en      : CPU-rate enable that qualifies every state change
//   apu_clk_en      : APU-rate enable; it steps the timer
//   half_clk_en     : half-frame tick; it clocks the length counter
//   wr_ctrl         : $4000 write (data_in[7:6]=duty, data_in[5]=halt)
//   wr_lo           : $4002 write (period[7:0])
//   wr_hi           : $4003 write (period[10:8], length index in [7:3])
//   data_in         : CPU write data
//   chan_enable     : $4015 enable bit; when low, length is held at 0
//   sweep_update    : single-cycle period load request from the sweep unit
//   sweep_period    : period that accompanies sweep_update
//   sweep_mute      : sweep unit mute condition
//   volume          : envelope / constant volume
//   timer_period    : current period register
//   length_nonzero  : length counter != 0
//   seq_step        : current sequencer step (0..7)
//   sample          : channel output sample
//
// Handshake: there is none. Every strobe input is a plain single-cycle
// qualifier. It takes effect on a clk edge where cpu_clk_en=1, and it is
// visible on the outputs from the following cycle.
// -----------------------------------------------------------------------------
module pulse_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk_en,
  input  logic        apu_clk_en,
  input  logic        half_clk_en,
  input  logic        wr_ctrl,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  data_in,
  input  logic        chan_enable,
  input  logic        sweep_update,
  input  logic [10:0] sweep_period,
  input  logic        sweep_mute,
  input  logic [3:0]  volume,
  output logic [10:0] timer_period,
  output logic        length_nonzero,
  output logic [2:0]  seq_step,
  output logic [3:0]  sample
);

  logic [10:0] r_period;
  logic [10:0] r_timer;
  logic [2:0]  r_step;
  logic [1:0]  r_duty;
  logic        r_halt;
  logic [7:0]  r_length;

  logic [10:0] w_period_next;
  logic        w_advance;
  logic [7:0]  w_len_load;
  logic [7:0]  w_duty_pattern;
  logic        w_duty_bit;

  // A CPU write to either period byte takes precedence over the sweep unit.
  // The sweep value is then dropped completely, so the untouched byte keeps
  // its old value. It does not take the sweep's bits.
  always_comb begin
    w_period_next = r_period;
    if (wr_lo || wr_hi) begin
      if (wr_lo) w_period_next[7:0]  = data_in;
      if (wr_hi) w_period_next[10:8] = data_in[2:0];
    end else if (sweep_update) begin
      w_period_next = sweep_period;
    end
  end

  // The timer counts P, P-1, ..., 0. It reloads on the tick where it reads 0,
  // so one advance happens every P+1 APU ticks.
  assign w_advance = apu_clk_en && (r_timer == 11'd0);

  always_comb begin
    w_len_load = 8'd0;
    case (data_in[7:3])
      5'd0:  w_len_load = 8'd10;
      5'd1:  w_len_load = 8'd254;
      5'd2:  w_len_load = 8'd20;
      5'd3:  w_len_load = 8'd2;
      5'd4:  w_len_load = 8'd40;
      5'd5:  w_len_load = 8'd4;
      5'd6:  w_len_load = 8'd80;
      5'd7:  w_len_load = 8'd6;
      5'd8:  w_len_load = 8'd160;
      5'd9:  w_len_load = 8'd8;
      5'd10: w_len_load = 8'd60;
      5'd11: w_len_load = 8'd10;
      5'd12: w_len_load = 8'd14;
      5'd13: w_len_load = 8'd12;
      5'd14: w_len_load = 8'd26;
      5'd15: w_len_load = 8'd14;
      5'd16: w_len_load = 8'd12;
      5'd17: w_len_load = 8'd16;
      5'd18: w_len_load = 8'd24;
      5'd19: w_len_load = 8'd18;
      5'd20: w_len_load = 8'd48;
      5'd21: w_len_load = 8'd20;
      5'd22: w_len_load = 8'd96;
      5'd23: w_len_load = 8'd22;
      5'd24: w_len_load = 8'd192;
      5'd25: w_len_load = 8'd24;
      5'd26: w_len_load = 8'd72;
      5'd27: w_len_load = 8'd26;
      5'd28: w_len_load = 8'd16;
      5'd29: w_len_load = 8'd28;
      5'd30: w_len_load = 8'd32;
      default: w_len_load = 8'd30;
    endcase
  end

  // Period, timer, sequencer step and control latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= 11'd0;
      r_timer  <= 11'd0;
      r_step   <= 3'd0;
      r_duty   <= 2'd0;
      r_halt   <= 1'b0;
    end else if (cpu_clk_en) begin
      r_period <= w_period_next;
      if (apu_clk_en) begin
        if (w_advance) r_timer <= r_period;
        else           r_timer <= r_timer - 11'd1;
      end
      // A $4003 write restarts the duty cycle. It has priority over an advance
      // in the same cycle. The timer count itself keeps running.
      if (wr_hi)          r_step <= 3'd0;
      else if (w_advance) r_step <= r_step + 3'd1;
      if (wr_ctrl) begin
        r_duty <= data_in[7:6];
        r_halt <= data_in[5];
      end
    end
  end

  // Length counter. A disabled channel clears it on every cycle, whether or
  // not the CPU enable is active. A load has priority over a half-frame
  // decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_length <= 8'd0;
    end else if (!chan_enable) begin
      r_length <= 8'd0;
    end else if (cpu_clk_en) begin
      if (wr_hi)
        r_length <= w_len_load;
      else if (half_clk_en && !r_halt && (r_length != 8'd0))
        r_length <= r_length - 8'd1;
    end
  end

  // Duty waveforms. Bit n is the output level at step n.
  always_comb begin
    case (r_duty)
      2'd0:    w_duty_pattern = 8'b0000_0010;
      2'd1:    w_duty_pattern = 8'b0000_0110;
      2'd2:    w_duty_pattern = 8'b0001_1110;
      default: w_duty_pattern = 8'b1111_1001;
    endcase
  end

  assign w_duty_bit     = w_duty_pattern[r_step];
  assign timer_period   = r_period;
  assign length_nonzero = (r_length != 8'd0);
  assign seq_step       = r_step;
  assign sample         = (length_nonzero && !sweep_mute && w_duty_bit) ? volume : 4'd0;

endmodule
